// File: rtl/stream_source.sv
// Programmable burst traffic source: incrementing or LFSR beats with idle gaps between accepted beats.
// Every output is registered; out_valid/out_data are held under backpressure and stall cycles are counted.
module stream_source #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int GAP_WIDTH   = 4,
  parameter int STALL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [DATA_WIDTH-1:0]  seed,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic [GAP_WIDTH-1:0]   gap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sent_count,
  output logic [STALL_WIDTH-1:0] stall_count
);

  localparam logic [DATA_WIDTH-1:0]  DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]   GAP_ONE   = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STALL_WIDTH-1:0] STALL_ONE = {{(STALL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]  LFSR_TAPS = DATA_WIDTH'(32'h80200003);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_mode, w_mode_nxt;
  logic [COUNT_WIDTH-1:0] r_length, w_length_nxt;
  logic [GAP_WIDTH-1:0]   r_gap, w_gap_nxt;
  logic [GAP_WIDTH-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [DATA_WIDTH-1:0]  r_data, w_data_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic [COUNT_WIDTH-1:0] r_sent, w_sent_nxt;
  logic [STALL_WIDTH-1:0] r_stall, w_stall_nxt;

  logic [DATA_WIDTH-1:0]  w_next_data;
  logic [DATA_WIDTH-1:0]  w_seed_eff;
  logic [COUNT_WIDTH-1:0] w_sent_inc;
  logic                   w_handshake;
  logic                   w_last;

  // LFSR is Galois, right-shifting; an all-zero LFSR seed would lock up, so it becomes 1.
  assign w_next_data = r_mode ? (r_data[0] ? ((r_data >> 1) ^ LFSR_TAPS) : (r_data >> 1))
                              : (r_data + DATA_ONE);
  assign w_seed_eff  = (mode && (seed == '0)) ? DATA_ONE : seed;
  assign w_handshake = r_valid && out_ready;
  assign w_sent_inc  = r_sent + COUNT_ONE;
  assign w_last      = (w_sent_inc == r_length);

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_length_nxt  = r_length;
    w_gap_nxt     = r_gap;
    w_gap_cnt_nxt = r_gap_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_sent_nxt    = r_sent;
    w_stall_nxt   = r_stall;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mode_nxt   = mode;
          w_length_nxt = length;
          w_gap_nxt    = gap;
          w_sent_nxt   = '0;
          w_stall_nxt  = '0;
          if (length != '0) begin
            w_state_nxt = S_SEND;
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_seed_eff;
            w_busy_nxt  = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (r_valid && !out_ready && (r_stall != '1)) begin
          w_stall_nxt = r_stall + STALL_ONE;
        end
        if (w_handshake) begin
          w_sent_nxt = w_sent_inc;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (r_gap == '0) begin
            w_data_nxt  = w_next_data;
          end else begin
            // Advance the payload now; it is only presented again when valid returns.
            w_state_nxt   = S_GAP;
            w_valid_nxt   = 1'b0;
            w_gap_cnt_nxt = r_gap;
            w_data_nxt    = w_next_data;
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_ONE) begin
          w_state_nxt = S_SEND;
          w_valid_nxt = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_length  <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sent    <= '0;
      r_stall   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_length  <= w_length_nxt;
      r_gap     <= w_gap_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_sent    <= w_sent_nxt;
      r_stall   <= w_stall_nxt;
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sent_count  = r_sent;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_stream_source.sv
// Bench for stream_source: fixed burst vectors, reset/ignored-start sequences, then random bursts
// with random backpressure compared against a list-based model of the expected beat stream.
module tb_stream_source;

  localparam int SW      = 4;
  localparam int STL_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [31:0]   seed;
  logic [15:0]   length;
  logic [3:0]    gap;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;
  logic          done;
  logic [15:0]   sent_count;
  logic [SW-1:0] stall_count;

  stream_source #(
    .DATA_WIDTH (32),
    .COUNT_WIDTH(16),
    .GAP_WIDTH  (4),
    .STALL_WIDTH(SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
    .length     (length),
    .gap        (gap),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_beats[$];

  typedef struct {
    logic        m;
    logic [31:0] s;
    logic [15:0] len;
    logic [3:0]  g;
    int          stall_first;
    bit          poke;
    logic [31:0] e0, e1, e2, e3;
    int          exp_stall;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Expected beat list straight from the pattern rules.
  task automatic build_model(input logic m, input logic [31:0] s, input logic [15:0] len);
    logic [31:0] d;
    exp_beats.delete();
    d = (m && s == 32'd0) ? 32'd1 : s;
    for (int i = 0; i < int'(len); i++) begin
      exp_beats.push_back(d);
      if (!m)        d = d + 32'd1;
      else if (d[0]) d = (d >> 1) ^ 32'h80200003;
      else           d = d >> 1;
    end
  endtask

  // Starts a burst in the current cycle and follows it to its done pulse.
  // exp_stall < 0 means: expect the saturated number of stall cycles the bench itself caused.
  task automatic run_burst(input logic m, input logic [31:0] s, input logic [15:0] len,
                           input logic [3:0] g, input int stall_first, input int rdy_pct,
                           input bit poke, input int exp_stall, input string name);
    logic [31:0] got[$];
    logic [31:0] prev_d;
    int stalls = 0, cyc = 0, run = 0;
    int hold_viol = 0, gap_viol = 0, busy_viol = 0, done_viol = 0;
    int es;
    bit in_gap = 0, prev_stall, finished = 0;

    mode = m; seed = s; length = len; gap = g; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 1'($urandom); seed = $urandom; length = 16'($urandom); gap = 4'($urandom);

    if (len == 16'd0) begin
      check({name, ".zero_done"},  64'(done), 64'd1);
      check({name, ".zero_valid"}, 64'(out_valid), 64'd0);
      check({name, ".zero_busy"},  64'(busy), 64'd0);
      @(posedge clk); #1;
      check({name, ".zero_done_drop"}, 64'(done), 64'd0);
      check({name, ".zero_valid2"},    64'(out_valid), 64'd0);
      return;
    end

    check({name, ".first_valid"}, 64'(out_valid), 64'd1);
    check({name, ".first_data"},  64'(out_data), 64'(exp_beats[0]));
    check({name, ".busy_on"},     64'(busy), 64'd1);
    check({name, ".sent_clr"},    64'(sent_count), 64'd0);
    check({name, ".stall_clr"},   64'(stall_count), 64'd0);

    while (!finished && cyc < 2000) begin
      if (cyc < stall_first) out_ready = 1'b0;
      else                   out_ready = ($urandom_range(99) < rdy_pct);
      start = poke && (cyc == 1);
      if (done) done_viol++;
      if (!busy) busy_viol++;
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      if (prev_stall) stalls++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        in_gap = 1;
        run = 0;
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (prev_stall && !(out_valid && out_data == prev_d)) hold_viol++;
      if (got.size() == int'(len)) begin
        finished = 1;
      end else if (in_gap) begin
        if (out_valid) begin
          if (run != int'(g)) gap_viol++;
          in_gap = 0;
        end else begin
          run++;
        end
      end
    end

    es = (exp_stall >= 0) ? exp_stall : ((stalls > STL_MAX) ? STL_MAX : stalls);
    check({name, ".completed"},   64'(finished), 64'd1);
    check({name, ".done_pulse"},  64'(done), 64'd1);
    check({name, ".end_valid"},   64'(out_valid), 64'd0);
    check({name, ".end_busy"},    64'(busy), 64'd0);
    check({name, ".beat_count"},  64'(got.size()), 64'(len));
    for (int i = 0; i < got.size() && i < exp_beats.size(); i++)
      check($sformatf("%s.beat%0d", name, i), 64'(got[i]), 64'(exp_beats[i]));
    check({name, ".sent_count"},  64'(sent_count), 64'(len));
    check({name, ".stall_count"}, 64'(stall_count), 64'(es));
    check({name, ".hold_viol"},   64'(hold_viol), 64'd0);
    check({name, ".gap_viol"},    64'(gap_viol), 64'd0);
    check({name, ".busy_viol"},   64'(busy_viol), 64'd0);
    check({name, ".done_viol"},   64'(done_viol), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{1'b0, 32'hDEADBEEF, 16'd4, 4'd0, 0,  1'b0, 32'hDEADBEEF, 32'hDEADBEF0, 32'hDEADBEF1, 32'hDEADBEF2, 0};
    vt[1] = '{1'b0, 32'h12345678, 16'd2, 4'd0, 3,  1'b0, 32'h12345678, 32'h12345679, 32'h0, 32'h0, 3};
    vt[2] = '{1'b0, 32'hFFFFFFFF, 16'd3, 4'd2, 0,  1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h0, 0};
    vt[3] = '{1'b1, 32'h00000001, 16'd3, 4'd0, 0,  1'b0, 32'h00000001, 32'h80200003, 32'hC0300002, 32'h0, 0};
    vt[4] = '{1'b1, 32'h00000000, 16'd3, 4'd0, 0,  1'b0, 32'h00000001, 32'h80200003, 32'hC0300002, 32'h0, 0};
    vt[5] = '{1'b0, 32'h00000042, 16'd0, 4'd0, 0,  1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0};
    vt[6] = '{1'b0, 32'h00000005, 16'd2, 4'd0, 20, 1'b0, 32'h00000005, 32'h00000006, 32'h0, 32'h0, STL_MAX};
    vt[7] = '{1'b0, 32'h00000064, 16'd4, 4'd1, 0,  1'b1, 32'h00000064, 32'h00000065, 32'h00000066, 32'h00000067, 0};

    rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; length = '0; gap = '0; out_ready = 1'b0;
    #3;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.data",  64'(out_data), 64'd0);
    check("rst.busy",  64'(busy), 64'd0);
    check("rst.done",  64'(done), 64'd0);
    check("rst.sent",  64'(sent_count), 64'd0);
    check("rst.stall", 64'(stall_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      exp_beats.delete();
      if (vt[i].len > 16'd0) exp_beats.push_back(vt[i].e0);
      if (vt[i].len > 16'd1) exp_beats.push_back(vt[i].e1);
      if (vt[i].len > 16'd2) exp_beats.push_back(vt[i].e2);
      if (vt[i].len > 16'd3) exp_beats.push_back(vt[i].e3);
      run_burst(vt[i].m, vt[i].s, vt[i].len, vt[i].g, vt[i].stall_first, 100,
                vt[i].poke, vt[i].exp_stall, $sformatf("vec%0d", i));
      @(posedge clk); #1;
      check($sformatf("vec%0d.done_drop", i), 64'(done), 64'd0);
    end

    // Asynchronous reset in the middle of a stalled burst.
    mode = 1'b0; seed = 32'h11111111; length = 16'd5; gap = 4'd0; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("arst.pre_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.busy",  64'(busy), 64'd0);
    check("arst.data",  64'(out_data), 64'd0);
    check("arst.sent",  64'(sent_count), 64'd0);
    check("arst.stall", 64'(stall_count), 64'd0);
    #1 rst = 1'b0;
    exp_beats.delete();
    exp_beats.push_back(32'hAAAABBBB);
    run_burst(1'b0, 32'hAAAABBBB, 16'd1, 4'd0, 0, 100, 1'b0, 0, "after_rst");

    // Random bursts issued back to back, so each start lands in the previous done cycle.
    for (int k = 0; k < 40; k++) begin
      logic        m;
      logic [31:0] s;
      logic [15:0] len;
      logic [3:0]  g;
      m   = 1'($urandom_range(1));
      s   = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      len = 16'($urandom_range(12));
      g   = 4'($urandom_range(3));
      build_model(m, s, len);
      run_burst(m, s, len, g, 0, $urandom_range(100, 40), 1'b0, -1, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_source.md
Name: stream_source

Overview:
- Transmitter end of the team's valid/ready stream interface; drives the in_* side of pipeline_register and other stream sinks.
- Generates a programmed burst of data beats (incrementing or LFSR pattern) with optional idle gaps between beats.
- Obeys backpressure strictly and reports completion and stall statistics.
- Used as on-chip traffic source for datapath bring-up and as a reusable producer in integration benches.

Parameters:
DATA_WIDTH, 32, data beat width; LFSR mode defined only for 32
COUNT_WIDTH, 16, width of burst length and sent counter
GAP_WIDTH, 4, width of inter-beat idle-cycle count
STALL_WIDTH, 16, width of saturating stall counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request to begin a burst (sampled only in IDLE)
mode  input  1  0 = increment pattern, 1 = LFSR pattern (latched on start)
seed  input  DATA_WIDTH  first beat value (latched on start)
length  input  COUNT_WIDTH  number of beats in burst (latched on start)
gap  input  GAP_WIDTH  idle cycles inserted after each accepted beat (latched on start)
out_valid  output  1  beat present on out_data
out_ready  input  1  downstream accepts beat
out_data  output  DATA_WIDTH  beat payload
busy  output  1  burst in progress (SEND or GAP)
done  output  1  one-cycle pulse when burst completes
sent_count  output  COUNT_WIDTH  beats accepted in current/last burst
stall_count  output  STALL_WIDTH  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, busy=0, done=0, sent_count=0, stall_count=0, state=IDLE. Reset mid-burst drops the in-flight beat; no resume.
- All outputs registered; no combinational path from out_ready or start to any output.
- States: IDLE, SEND, GAP.
- IDLE: on start=1, latch mode/seed/length/gap, clear sent_count and stall_count.
  - length!=0: go SEND; out_valid=1, out_data=seed, busy=1 in the cycle after start.
  - length==0: stay IDLE; done=1 for the next cycle only; no beat is sent.
  - Seed 0 in LFSR mode: substitute 1.
- start while busy=1 is ignored; latched parameters do not change mid-burst.
- Handshake: a beat transfers at a rising edge where out_valid=1 and out_ready=1.
- SEND: out_valid and out_data held stable until handshake; no data change or valid drop under backpressure.
  - Each cycle out_valid=1 and out_ready=0: stall_count+1, saturating at all-ones.
- On handshake in SEND, sent_count+1, then:
  - Last beat (sent_count+1==length): go IDLE; out_valid=0, busy=0, done=1 for exactly one cycle. start in that done cycle is accepted.
  - Else if gap==0: stay SEND; next value on out_data, out_valid stays 1 (one beat per cycle sustained).
  - Else: go GAP; out_valid=0 for exactly gap cycles, then SEND with next value.
- Next value:
  - Increment: out_data+1, wraps modulo 2^DATA_WIDTH.
  - LFSR (Galois, right shift): if lsb=1, (d>>1) xor 32'h80200003, else d>>1.
- done is never asserted while out_valid=1.

Test Plan:
1. seed=0xDEADBEEF, length=4, gap=0, mode=0, out_ready=1 -> beats 0xDEADBEEF, 0xDEADBEF0, 0xDEADBEF1, 0xDEADBEF2 on 4 consecutive cycles starting the cycle after start; done pulses one cycle after last beat; sent_count=4, stall_count=0.
2. seed=0x12345678, length=2, out_ready low for 3 cycles then high -> out_valid/out_data held at 0x12345678 for 3 cycles, stall_count=3, then beats 0x12345678, 0x12345679 accepted once each (no loss, no duplication).
3. seed=0xFFFFFFFF, length=3, gap=2, out_ready=1 -> beats 0xFFFFFFFF, 0x00000000, 0x00000001 (wrap), with out_valid low exactly 2 cycles between beats; busy high throughout burst.
4. mode=1, seed=1, length=3 -> beats 0x00000001, 0x80200003, 0xC0300002. Repeat with seed=0 -> first beat 0x00000001.
5. length=0 start -> done one cycle later, out_valid never high. Second start pulse while busy mid-burst -> ignored, sent_count continues unchanged.
6. rst asserted mid-burst while out_valid=1 -> out_valid, busy, counters 0 without waiting for clk edge. After release, a new start with seed=0xAAAABBBB, length=1 -> single beat 0xAAAABBBB, done pulse.
